// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: op and FSM state encodings shared by the load/store unit
package mem_access_unit_pkg;
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE} state_e;
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// lsu_lane_align: byte-lane select, store replication, legality and load extraction
module lsu_lane_align (
  input  logic        we_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wrep_o,
  output logic [31:0] ldata_o,
  output logic        illegal_o
);
  logic bsz, hsz, wsz, sx;
  logic [31:0] sh;
  assign bsz = op_i[1:0] == 2'b00;
  assign hsz = op_i[1:0] == 2'b01;
  assign wsz = op_i[1:0] == 2'b11;
  assign sx  = ~op_i[2];
  assign illegal_o = (op_i[1:0] == 2'b10) | (op_i[2] & op_i[1]) | (we_i & op_i[2]) |
                     (hsz & off_i[0]) | (wsz & (off_i != 2'b00));
  assign sel_o  = wsz ? 4'hF : hsz ? (off_i[1] ? 4'hC : 4'h3) : 4'b0001 << off_i;
  assign wrep_o = bsz ? {4{wdata_i[7:0]}} : hsz ? {2{wdata_i[15:0]}} : wdata_i;
  assign sh = rdata_i >> {off_i, 3'b000};
  assign ldata_o = bsz ? {{24{sx & sh[7]}}, sh[7:0]} :
                   hsz ? {{16{sx & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS load/store front end driving a byte-enabled, registered-read memory
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 20,
  parameter int MEM_DATA_BITS = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_op,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic                     resp_err,
  output logic [31:0]              resp_rdata,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [MEM_DATA_BITS-1:0] mem_data_in,
  output logic [3:0]               mem_sel,
  output logic                     mem_str,
  output logic                     mem_ld,
  input  logic [MEM_DATA_BITS-1:0] mem_data_out
);
  state_e state_q, state_d;
  logic we_q, rv_q, rv_d, err_q, err_d, idle, access, accept, illegal;
  logic [2:0] op_q;
  logic [MEM_ADDR_BITS+1:0] addr_q;
  logic [31:0] wdata_q, rdata_q, rdata_d, wrep, ldata;
  logic [3:0] sel;
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_ADDR_BITS+2];
  assign idle   = state_q == S_IDLE;
  assign access = state_q == S_ACCESS;
  assign accept = idle & req_valid;
  // legality is judged on the live request in IDLE; afterwards the latched copy drives the lanes
  lsu_lane_align u_align (
    .we_i      (idle ? req_we : we_q),
    .op_i      (idle ? req_op : op_q),
    .off_i     (idle ? req_addr[1:0] : addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_data_out),
    .sel_o     (sel),
    .wrep_o    (wrep),
    .ldata_o   (ldata),
    .illegal_o (illegal)
  );
  always_comb begin
    state_d = state_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'd0;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = illegal ? S_IDLE : S_ACCESS;
        rv_d    = illegal;
        err_d   = illegal;
      end
      S_ACCESS: begin
        state_d = we_q ? S_IDLE : S_CAPTURE;
        rv_d    = we_q;
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        rv_d    = 1'b1;
        rdata_d = ldata;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= req_we;
        op_q    <= req_op;
        addr_q  <= req_addr[MEM_ADDR_BITS+1:0];
        wdata_q <= req_wdata;
      end
    end
  end
  assign req_ready   = idle & ~clr;
  assign resp_valid  = rv_q;
  assign resp_err    = err_q;
  assign resp_rdata  = rdata_q;
  assign mem_addr    = addr_q[MEM_ADDR_BITS+1:2];
  assign mem_data_in = wrep;
  assign mem_sel     = access ? sel : 4'h0;
  assign mem_str     = access & we_q & ~clr;
  assign mem_ld      = access & ~we_q & ~clr;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store vectors against a byte-enabled memory model
module tb_mem_access_unit;
  logic clk = 1'b0, clr = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic req_ready, resp_valid, resp_err, mem_str, mem_ld;
  logic [31:0] resp_rdata, mem_data_in, mem_data_out, cap_din;
  logic [19:0] mem_addr, cap_addr;
  logic [3:0] mem_sel;
  logic [31:0] mem [0:255];
  logic unused_tb;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign unused_tb = ^mem_addr[19:8];
  mem_access_unit dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_sel(mem_sel), .mem_str(mem_str), .mem_ld(mem_ld), .mem_data_out(mem_data_out)
  );
  always @(posedge clk) begin
    if (mem_str)
      for (int b = 0; b < 4; b++)
        if (mem_sel[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_data_in[8*b +: 8];
    if (mem_ld) mem_data_out <= mem[mem_addr[7:0]];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic err, input logic [3:0] esel, input logic [31:0] erd, input string tag);
    int lat;
    lat = err ? 1 : (we ? 2 : 3);
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'd0; req_op = 3'b010;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, ".sel"}, 32'(mem_sel), err ? 32'd0 : 32'(esel));
        chk({tag, ".str"}, 32'(mem_str), 32'(!err && we));
        chk({tag, ".ld"}, 32'(mem_ld), 32'(!err && !we));
        cap_addr = mem_addr;
        cap_din  = mem_data_in;
      end
      chk({tag, ".rv"}, 32'(resp_valid), 32'(c == lat));
      if (c == lat) begin
        chk({tag, ".err"}, 32'(resp_err), 32'(err));
        chk({tag, ".rd"}, resp_rdata, erd);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst.rv", 32'(resp_valid), 32'd0);
    chk("rst.err", 32'(resp_err), 32'd0);
    chk("rst.rd", resp_rdata, 32'd0);
    chk("rst.rdy", 32'(req_ready), 32'd1);
    chk("rst.sel", 32'(mem_sel), 32'd0);
    run(1'b1, 3'b011, 32'h10, 32'hDEADBEEF, 1'b0, 4'hF, 32'd0, "sw10");
    chk("sw10.addr", 32'(cap_addr), 32'd4);
    chk("sw10.din", cap_din, 32'hDEADBEEF);
    run(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0, 4'h8, 32'd0, "sb13");
    chk("sb13.din", cap_din, 32'hA5A5A5A5);
    run(1'b0, 3'b000, 32'h13, 32'd0, 1'b0, 4'h8, 32'hFFFFFFA5, "lb13");
    run(1'b0, 3'b100, 32'h13, 32'd0, 1'b0, 4'h8, 32'h000000A5, "lbu13");
    run(1'b0, 3'b011, 32'h10, 32'd0, 1'b0, 4'hF, 32'hA5ADBEEF, "lw10");
    run(1'b0, 3'b000, 32'h11, 32'd0, 1'b0, 4'h2, 32'hFFFFFFBE, "lb11");
    run(1'b0, 3'b100, 32'h10, 32'd0, 1'b0, 4'h1, 32'h000000EF, "lbu10");
    run(1'b0, 3'b001, 32'h12, 32'd0, 1'b0, 4'hC, 32'hFFFFA5AD, "lh12");
    run(1'b1, 3'b001, 32'h22, 32'h00008001, 1'b0, 4'hC, 32'd0, "sh22");
    chk("sh22.addr", 32'(cap_addr), 32'd8);
    chk("sh22.din", cap_din, 32'h80018001);
    run(1'b0, 3'b001, 32'h22, 32'd0, 1'b0, 4'hC, 32'hFFFF8001, "lh22");
    run(1'b0, 3'b101, 32'h22, 32'd0, 1'b0, 4'hC, 32'h00008001, "lhu22");
    run(1'b0, 3'b011, 32'h06, 32'd0, 1'b1, 4'h0, 32'd0, "lw06");
    run(1'b1, 3'b001, 32'h01, 32'h1234, 1'b1, 4'h0, 32'd0, "sh01");
    run(1'b0, 3'b010, 32'h10, 32'd0, 1'b1, 4'h0, 32'd0, "op010");
    run(1'b1, 3'b100, 32'h10, 32'h55, 1'b1, 4'h0, 32'd0, "sbu");
    run(1'b0, 3'b011, 32'h10, 32'd0, 1'b0, 4'hF, 32'hA5ADBEEF, "lw10b");
    run(1'b0, 3'b011, 32'hFFC0_0010, 32'd0, 1'b0, 4'hF, 32'hA5ADBEEF, "wrap");
    run(1'b1, 3'b011, 32'h30, 32'h11111111, 1'b0, 4'hF, 32'd0, "sw30");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b011; req_addr = 32'h30; req_wdata = 32'h22222222;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("clr.str_pre", 32'(mem_str), 32'd1);
    clr = 1'b1;
    #1 chk("clr.str", 32'(mem_str), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    #1 chk("clr.rdy", 32'(req_ready), 32'd1);
    chk("clr.rv", 32'(resp_valid), 32'd0);
    run(1'b0, 3'b011, 32'h30, 32'd0, 1'b0, 4'hF, 32'h11111111, "lw30");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b011; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b.rv_sw", 32'(resp_valid), 32'd1);
    chk("b2b.rdy", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b011; req_addr = 32'h40;
    @(negedge clk);
    chk("b2b.ld", 32'(mem_ld), 32'd1);
    chk("b2b.busy1", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("b2b.busy2", 32'(req_ready), 32'd0);
    chk("b2b.ld2", 32'(mem_ld), 32'd0);
    chk("b2b.rv2", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("b2b.rv3", 32'(resp_valid), 32'd1);
    chk("b2b.rd", resp_rdata, 32'hCAFEF00D);
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b.rv4", 32'(resp_valid), 32'd0);
    chk("b2b.ld4", 32'(mem_ld), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
